// File: rtl/dma_pkg.sv
// Shared constants, header field positions and state type for the DMA receive path.
package dma_pkg;

  localparam int DMA_BEAT_W = 128;
  localparam int DMA_WORD_W = 32;
  localparam int DMA_LANES  = 4;

  localparam logic [15:0] DMA_HDR_MAGIC = 16'hD5A7;

  localparam int MAGIC_HI = 31;
  localparam int MAGIC_LO = 16;
  localparam int LEN_HI   = 15;
  localparam int LEN_LO   = 0;

  typedef enum logic {
    RX_HDR,
    RX_PAYLOAD
  } rx_state_e;

  function automatic logic [DMA_WORD_W-1:0] beat_lane(
    input logic [DMA_BEAT_W-1:0] beat,
    input logic [1:0]            lane
  );
    return beat[lane*DMA_WORD_W +: DMA_WORD_W];
  endfunction

endpackage

// File: rtl/dma_rx_fifo.sv
// Show-ahead FIFO: rdata always presents the oldest stored entry; pop consumes it.
module dma_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dma_rx_unpacker.sv
// Unpacks framed 128-bit DMA beats into a 32-bit valid/ready word stream.
// Optional statistics counters are built when DMA_RX_STATS_EN is defined.
module dma_rx_unpacker
  import dma_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] HDR_MAGIC  = DMA_HDR_MAGIC,
  localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DMA_BEAT_W-1:0] dma_read_data,
  input  logic                  dma_read_valid,
  output logic [DMA_WORD_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic                  frame_err,
  output logic [31:0]           frame_cnt,
  output logic [31:0]           drop_cnt
);

  logic [DMA_BEAT_W-1:0] head;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  hdr_bad;
  logic                  hs;
  rx_state_e             state;
  logic [1:0]            lane;
  logic [15:0]           rem;
  logic [15:0]           hdr_len;

  dma_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DMA_BEAT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (dma_read_valid),
    .wdata   (dma_read_data),
    .pop     (pop),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign hdr_len   = head[LEN_HI:LEN_LO];
  assign hdr_bad   = (state == RX_HDR) & ~empty & (head[MAGIC_HI:MAGIC_LO] != HDR_MAGIC);
  assign out_valid = (state == RX_PAYLOAD) & ~empty;
  assign out_last  = out_valid & (rem == 16'd1);
  assign out_data  = out_valid ? beat_lane(head, lane) : '0;
  assign hs        = out_valid & out_ready;

  // A beat leaves the FIFO when its header is rejected or empty, or its last used lane is taken.
  always_comb begin
    pop = 1'b0;
    case (state)
      RX_HDR:     pop = hdr_bad | (~empty & (hdr_len == 16'd0));
      RX_PAYLOAD: pop = hs & ((rem == 16'd1) | (lane == 2'(DMA_LANES - 1)));
      default:    pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RX_HDR;
      lane      <= '0;
      rem       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= hdr_bad;
      case (state)
        RX_HDR: begin
          if (~empty && !hdr_bad && hdr_len != 16'd0) begin
            rem   <= hdr_len;
            lane  <= 2'd1;
            state <= RX_PAYLOAD;
          end
        end
        RX_PAYLOAD: begin
          if (hs) begin
            rem <= rem - 16'd1;
            if (rem == 16'd1) begin
              lane  <= '0;
              state <= RX_HDR;
            end else begin
              lane <= lane + 2'd1;
            end
          end
        end
        default: state <= RX_HDR;
      endcase
    end
  end

  // A new drop wins over a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  overflow <= 1'b0;
    else if (dma_read_valid & full) overflow <= 1'b1;
    else if (ovf_clr)              overflow <= 1'b0;
  end

`ifdef DMA_RX_STATS_EN
  logic frame_done;

  assign frame_done = ((state == RX_HDR) & ~empty & ~hdr_bad & (hdr_len == 16'd0)) |
                      (hs & (rem == 16'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (frame_done)            frame_cnt <= frame_cnt + 32'd1;
      if (dma_read_valid & full) drop_cnt  <= drop_cnt + 32'd1;
    end
  end
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_dma_rx_unpacker.sv
// Directed bench for dma_rx_unpacker; expected values are hand-computed per vector.
module tb_dma_rx_unpacker;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [127:0] dma_read_data = '0;
  logic         dma_read_valid = 1'b0;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic [4:0]   fifo_level;
  logic         overflow;
  logic         ovf_clr = 1'b0;
  logic         frame_err;
  logic [31:0]  frame_cnt;
  logic [31:0]  drop_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int exp_frames = 0;
  int exp_drops  = 0;

  dma_rx_unpacker #(.FIFO_DEPTH(16), .HDR_MAGIC(16'hD5A7)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dma_read_data  (dma_read_data),
    .dma_read_valid (dma_read_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .ovf_clr        (ovf_clr),
    .frame_err      (frame_err),
    .frame_cnt      (frame_cnt),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] hdr(input logic [15:0] n);
    return {16'hD5A7, n};
  endfunction

  task automatic send_beat(input logic [127:0] d);
    dma_read_data  = d;
    dma_read_valid = 1'b1;
    tick();
    dma_read_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    exp_frames = 0;
    exp_drops  = 0;
  endtask

  task automatic pop_word(input string tag, input logic [31:0] d, input logic l);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
    tick();
  endtask

  task automatic check_stats(input string tag);
`ifdef DMA_RX_STATS_EN
    check({tag, "_fcnt"}, frame_cnt, exp_frames);
    check({tag, "_dcnt"}, drop_cnt, exp_drops);
`else
    check({tag, "_fcnt"}, frame_cnt, 32'd0);
    check({tag, "_dcnt"}, drop_cnt, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_lvl", {27'd0, fifo_level}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check_stats("rst");
    reset_n = 1'b1;
    tick();

    // Single beat, three payload words.
    out_ready = 1'b1;
    send_beat({32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000, hdr(16'd3)});
    check("t1_lvl", {27'd0, fifo_level}, 32'd1);
    check("t1_nv", {31'd0, out_valid}, 32'd0);
    tick();
    check("t1_v", {31'd0, out_valid}, 32'd1);
    pop_word("t1_w0", 32'hC0DE0000, 1'b0);
    pop_word("t1_w1", 32'hC0DE0001, 1'b0);
    pop_word("t1_w2", 32'hC0DE0002, 1'b1);
    exp_frames++;
    check("t1_lvl0", {27'd0, fifo_level}, 32'd0);
    check("t1_idle", {31'd0, out_valid}, 32'd0);
    check_stats("t1");

    // Six words over two beats; lane 3 of the second beat discarded.
    send_beat({32'h10000002, 32'h10000001, 32'h10000000, hdr(16'd6)});
    send_beat({32'hDEADBEEF, 32'h10000005, 32'h10000004, 32'h10000003});
    for (int i = 0; i < 6; i++)
      pop_word($sformatf("t2_w%0d", i), 32'h10000000 + i, i == 5);
    exp_frames++;
    check("t2_lvl0", {27'd0, fifo_level}, 32'd0);
    tick();
    check("t2_idle", {31'd0, out_valid}, 32'd0);

    // Bad magic is dropped with a single frame_err pulse.
    send_beat({32'h33333333, 32'h22222222, 32'h11111111, 32'h12340003});
    check("t3_ferr0", {31'd0, frame_err}, 32'd0);
    tick();
    check("t3_ferr1", {31'd0, frame_err}, 32'd1);
    check("t3_nv", {31'd0, out_valid}, 32'd0);
    check("t3_lvl", {27'd0, fifo_level}, 32'd0);
    tick();
    check("t3_ferr2", {31'd0, frame_err}, 32'd0);
    send_beat({32'h0, 32'h0, 32'hABCD0001, hdr(16'd1)});
    pop_word("t3_w0", 32'hABCD0001, 1'b1);
    exp_frames++;
    check_stats("t3");

    // Empty frame followed by a one-word frame.
    send_beat({96'h0, hdr(16'd0)});
    send_beat({32'h0, 32'h0, 32'h5A5A5A5A, hdr(16'd1)});
    exp_frames++;
    pop_word("t5_w0", 32'h5A5A5A5A, 1'b1);
    exp_frames++;
    check_stats("t5");
    check("t5_lvl", {27'd0, fifo_level}, 32'd0);

    // Asynchronous reset while mid-payload.
    out_ready = 1'b0;
    send_beat({32'h77770002, 32'h77770001, 32'h77770000, hdr(16'd3)});
    tick();
    check("t6_mid", {31'd0, out_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_vld", {31'd0, out_valid}, 32'd0);
    check("t6_data", out_data, 32'd0);
    check("t6_last", {31'd0, out_last}, 32'd0);
    check("t6_lvl", {27'd0, fifo_level}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    exp_frames = 0;
    exp_drops  = 0;
    check_stats("t6_rst");
    out_ready = 1'b1;
    send_beat({32'h0, 32'h88880001, 32'h88880000, hdr(16'd2)});
    pop_word("t6_w0", 32'h88880000, 1'b0);
    pop_word("t6_w1", 32'h88880001, 1'b1);
    exp_frames++;
    check_stats("t6");

    // Overflow: 17 beats into a 16-deep FIFO with no draining.
    do_reset();
    out_ready = 1'b0;
    send_beat({96'h0, hdr(16'd100)});
    for (int i = 1; i < 16; i++) send_beat({4{i[31:0]}});
    check("t4_lvl16", {27'd0, fifo_level}, 32'd16);
    check("t4_ovf0", {31'd0, overflow}, 32'd0);
    send_beat({4{32'hFFFF0011}});
    exp_drops++;
    check("t4_lvl_hold", {27'd0, fifo_level}, 32'd16);
    check("t4_ovf1", {31'd0, overflow}, 32'd1);
    check_stats("t4");
    // A drop in the same cycle as the clear keeps the flag set.
    ovf_clr = 1'b1;
    send_beat({4{32'hFFFF0012}});
    exp_drops++;
    check("t4_ovf_pri", {31'd0, overflow}, 32'd1);
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_clr", {31'd0, overflow}, 32'd0);
    check_stats("t4b");
    check("t4_lvl_end", {27'd0, fifo_level}, 32'd16);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
